// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer.
// Holds the 128-bit cipher state and the round counter, and applies
// sub_bytes/shift_rows/mix_columns/add-round-key once per round. Round keys
// come from an external key store addressed by key_idx_o; the store answers
// combinationally in the same cycle.
// Optional build macro AES_ROUND_REG_EN: inserts a 128-bit register after
// shift_rows(sub_bytes(state)) so each round takes two cycles (SUB, MIX/ARK),
// with key_idx_o held across both cycles of a round.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready; on start_i loads data_in ^ rk[0]
// S_RUN      | full rounds 1..NR-1 (single-cycle build)
// S_FINAL    | last round without mix_columns, writes data_out, pulses done_o
// S_RUN_SUB  | full round, first half: register shift_rows(sub_bytes(state))
// S_RUN_MIX  | full round, second half: mix_columns + add round key
// S_FIN_SUB  | last round, first half
// S_FIN_MIX  | last round, second half: writes data_out, pulses done_o

module aes_round_ctrl #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [127:0]      data_in,
  output logic              ready_o,
  output logic              busy_o,
  output logic [KIDX_W-1:0] key_idx_o,
  input  logic [127:0]      round_key_i,
  output logic [127:0]      data_out,
  output logic              done_o
);

  localparam logic [KIDX_W-1:0] FIRST_RND = KIDX_W'(1);
  localparam logic [KIDX_W-1:0] LAST_RUN  = KIDX_W'(NR - 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_ROUND_REG_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN_SUB, S_RUN_MIX, S_FIN_SUB, S_FIN_MIX} fsm_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} fsm_t;
`endif

  fsm_t               fsm;
  logic [KIDX_W-1:0]  rnd;
  logic [127:0]       aes_state;
  logic [127:0]       sr_sb;
  logic [127:0]       round_out;
  logic [127:0]       final_out;

  // Byte 0 is the most significant byte; byte index = 4*column + row.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  assign sr_sb = shift_rows(sub_bytes(aes_state));

`ifdef AES_ROUND_REG_EN
  logic [127:0] pipe_q;
  assign round_out = mix_columns(pipe_q) ^ round_key_i;
  assign final_out = pipe_q ^ round_key_i;
`else
  assign round_out = mix_columns(sr_sb) ^ round_key_i;
  assign final_out = sr_sb ^ round_key_i;
`endif

  // ready/busy decode straight from the state register, so they are glitch-free
  assign ready_o = (fsm == S_IDLE);
  assign busy_o  = ~ready_o;

  // Round sequencer: advances state, round counter, key index and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= S_IDLE;
      rnd       <= '0;
      key_idx_o <= '0;
      aes_state <= '0;
      data_out  <= '0;
      done_o    <= 1'b0;
`ifdef AES_ROUND_REG_EN
      pipe_q    <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start_i) begin
            aes_state <= data_in ^ round_key_i;
            rnd       <= FIRST_RND;
            key_idx_o <= FIRST_RND;
`ifdef AES_ROUND_REG_EN
            fsm       <= (NR == 1) ? S_FIN_SUB : S_RUN_SUB;
`else
            fsm       <= (NR == 1) ? S_FINAL : S_RUN;
`endif
          end
        end
`ifdef AES_ROUND_REG_EN
        S_RUN_SUB: begin
          pipe_q <= sr_sb;
          fsm    <= S_RUN_MIX;
        end
        S_RUN_MIX: begin
          aes_state <= round_out;
          rnd       <= rnd + FIRST_RND;
          key_idx_o <= rnd + FIRST_RND;
          fsm       <= (rnd == LAST_RUN) ? S_FIN_SUB : S_RUN_SUB;
        end
        S_FIN_SUB: begin
          pipe_q <= sr_sb;
          fsm    <= S_FIN_MIX;
        end
        S_FIN_MIX: begin
          data_out  <= final_out;
          done_o    <= 1'b1;
          rnd       <= '0;
          key_idx_o <= '0;
          fsm       <= S_IDLE;
        end
`else
        S_RUN: begin
          aes_state <= round_out;
          rnd       <= rnd + FIRST_RND;
          key_idx_o <= rnd + FIRST_RND;
          if (rnd == LAST_RUN) begin
            fsm <= S_FINAL;
          end
        end
        S_FINAL: begin
          data_out  <= final_out;
          done_o    <= 1'b1;
          rnd       <= '0;
          key_idx_o <= '0;
          fsm       <= S_IDLE;
        end
`endif
        default: begin
          fsm       <= S_IDLE;
          rnd       <= '0;
          key_idx_o <= '0;
        end
      endcase
    end
  end

endmodule
